// File: rtl/actuator_pulse_gen.sv
// Three-channel actuator pulse generator with windowed, clipped durations.
// Optional one-deep pending command buffer: define ACT_CMD_BUF_EN.
module actuator_pulse_gen #(
  parameter int WID_8     = 8,
  parameter int WID_16    = 16,
  parameter int TICK_DIV  = 96,
  parameter int GAP_TICKS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WID_8-1:0]  cmd_vld,
  input  logic [WID_16-1:0] cmd_time,
  input  logic [WID_16-1:0] cmd_ta,
  input  logic [WID_16-1:0] cmd_tb,
  input  logic [WID_16-1:0] cmd_tc,
  output logic [2:0]        act_out,
  output logic              busy,
  output logic              done,
  output logic              cmd_drop,
  output logic              clip_flag
);

  localparam int PW      = $clog2(TICK_DIV);
  localparam int GAP_CYC = GAP_TICKS * TICK_DIV;

  typedef struct packed {
    logic [2:0]        en;
    logic [WID_16-1:0] tw;
    logic [WID_16-1:0] ta;
    logic [WID_16-1:0] tb;
    logic [WID_16-1:0] tc;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, DONE, GAP
  } state_t;

  state_t                  state, state_nx;
  cmd_t                    cmd_new, cur, load_cmd;
  logic                    cmd_in, buf_vld;
  logic                    wrap, last;
  logic [PW-1:0]           presc;
  logic [WID_16-1:0]       tick_cnt, tick_nx;
  logic [31:0]             gap_cnt;
  logic [2:0][WID_16-1:0]  t_raw, teff, teff_c;
  logic [2:0]              clip_c, act_nx;

  assign cmd_new = {cmd_vld[2:0], cmd_time, cmd_ta, cmd_tb, cmd_tc};
  assign cmd_in  = |cmd_vld;
  assign wrap    = presc == PW'(TICK_DIV - 1);
  assign last    = tick_cnt == cur.tw - 1'b1;
  assign tick_nx = tick_cnt + 1'b1;
  assign t_raw   = {cur.tc, cur.tb, cur.ta};

`ifdef ACT_CMD_BUF_EN
  cmd_t buf_cmd;
  logic take_buf, store;

  // A command landing as the buffer drains refills it.
  assign take_buf = (state == IDLE) && buf_vld;
  assign store    = cmd_in && (state != IDLE || buf_vld)
                    && (!buf_vld || take_buf);
  assign cmd_drop = cmd_in && (state != IDLE) && buf_vld;
  assign load_cmd = buf_vld ? buf_cmd : cmd_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld <= 1'b0;
      buf_cmd <= '0;
    end else if (store) begin
      buf_vld <= 1'b1;
      buf_cmd <= cmd_new;
    end else if (take_buf) begin
      buf_vld <= 1'b0;
    end
  end
`else
  assign buf_vld  = 1'b0;
  assign cmd_drop = cmd_in && (state != IDLE);
  assign load_cmd = cmd_new;
`endif

  always_comb begin
    teff_c = '0;
    clip_c = '0;
    for (int i = 0; i < 3; i++) begin
      if (cur.en[i]) begin
        teff_c[i] = (t_raw[i] > cur.tw) ? cur.tw : t_raw[i];
        clip_c[i] = t_raw[i] > cur.tw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (buf_vld || cmd_in) state_nx = LOAD;
      LOAD: state_nx = (cur.tw == '0) ? DONE : RUN;
      RUN:  if (wrap && last) state_nx = DONE;
      DONE: state_nx = (GAP_TICKS == 0) ? IDLE : GAP;
      GAP:  if (gap_cnt == 32'(GAP_CYC - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end

  // Next act_out value for the cycle being entered.
  always_comb begin
    act_nx = '0;
    if (state == LOAD && cur.tw != '0) begin
      for (int i = 0; i < 3; i++) act_nx[i] = teff_c[i] != '0;
    end else if (state == RUN) begin
      if (!wrap) act_nx = act_out;
      else if (!last)
        for (int i = 0; i < 3; i++) act_nx[i] = tick_nx < teff[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      teff      <= '0;
      presc     <= '0;
      tick_cnt  <= '0;
      gap_cnt   <= '0;
      act_out   <= '0;
      clip_flag <= 1'b0;
    end else begin
      if (state == IDLE && (buf_vld || cmd_in)) cur <= load_cmd;
      unique case (state)
        LOAD: begin
          teff     <= teff_c;
          presc    <= '0;
          tick_cnt <= '0;
          if (|clip_c) clip_flag <= 1'b1;
        end
        RUN: begin
          presc <= wrap ? '0 : presc + 1'b1;
          if (wrap && !last) tick_cnt <= tick_nx;
        end
        DONE: gap_cnt <= '0;
        GAP:  gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
      act_out <= act_nx;
    end
  end

endmodule
